// File: rtl/apb2_led_pwm.sv
// apb2_led_pwm: APB2 slave (pclk, preset_n, psel/penable/pwrite/paddr/pwdata/pstrb/pprot in; prdata/pready/pslverr out) driving led_state with per-channel PWM and blink
module apb2_led_pwm #(
  parameter int data_width = 32,
  parameter int addr_width = 8,
  parameter int led_count = 4,
  parameter int pwm_width = 8
) (
  input  logic                    pclk,
  input  logic                    preset_n,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [addr_width-1:0]   paddr,
  input  logic [data_width-1:0]   pwdata,
  input  logic [data_width/8-1:0] pstrb,
  input  logic [2:0]              pprot,
  output logic [data_width-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr,
  output logic [led_count-1:0]    led_state
);
  localparam int aw = addr_width - 2;
  typedef logic [aw-1:0] wa_t;
  logic [led_count-1:0] enable;
  logic [15:0] prescale;
  logic [15:0] blink_half;
  logic [pwm_width-1:0] duty [led_count];
  logic [led_count-1:0] blink_en;
  logic [15:0] presc_cnt;
  logic [pwm_width-1:0] pwm_cnt;
  logic [15:0] blink_cnt;
  logic blink_phase;
  wa_t wa;
  logic s_en, s_pre, s_bh, s_st, err, access, wr, tick, period_end;
  logic [led_count-1:0] s_ch;
  logic [data_width-1:0] rd_val, m, wv;
  logic unused_ok;
  assign wa = paddr[addr_width-1:2];
  assign s_en = wa == wa_t'(0);
  assign s_pre = wa == wa_t'(1);
  assign s_bh = wa == wa_t'(2);
  assign s_st = wa == wa_t'(3);
  always_comb begin
    s_ch = '0;
    for (int i = 0; i < led_count; i++) s_ch[i] = wa == wa_t'(4 + i);
  end
  assign err = (paddr[1:0] != 2'b00) | ~(s_en | s_pre | s_bh | s_st | (|s_ch)) | (pwrite & s_st);
  assign access = psel & penable & ~pready;
  assign wr = access & pwrite & ~err;
  always_comb begin
    rd_val = '0;
    if (s_en) rd_val[led_count-1:0] = enable;
    if (s_pre) rd_val[15:0] = prescale;
    if (s_bh) rd_val[15:0] = blink_half;
    if (s_st) begin
      rd_val[led_count-1:0] = led_state;
      rd_val[16] = blink_phase;
    end
    for (int i = 0; i < led_count; i++)
      if (s_ch[i]) begin
        rd_val[pwm_width-1:0] = duty[i];
        rd_val[16] = blink_en[i];
      end
  end
  // Writes merge strobed byte lanes into the register's current read-back image.
  always_comb begin
    m = '0;
    for (int b = 0; b < data_width / 8; b++) m[b*8 +: 8] = {8{pstrb[b]}};
  end
  assign wv = (rd_val & ~m) | (pwdata & m);
  assign tick = presc_cnt >= prescale;
  assign period_end = tick & (&pwm_cnt);
  assign unused_ok = &{1'b0, pprot, wv};
  always_ff @(posedge pclk) begin
    if (!preset_n) begin
      enable <= '0;
      prescale <= '0;
      blink_half <= '0;
      blink_en <= '0;
      for (int i = 0; i < led_count; i++) duty[i] <= '0;
      presc_cnt <= '0;
      pwm_cnt <= '0;
      blink_cnt <= '0;
      blink_phase <= 1'b1;
      led_state <= '0;
      pready <= 1'b0;
      pslverr <= 1'b0;
      prdata <= '0;
    end else begin
      pready <= access;
      pslverr <= access & err;
      prdata <= (access & ~pwrite & ~err) ? rd_val : '0;
      if (wr & s_en) enable <= wv[led_count-1:0];
      if (wr & s_pre) prescale <= wv[15:0];
      if (wr & s_bh) blink_half <= wv[15:0];
      for (int i = 0; i < led_count; i++)
        if (wr & s_ch[i]) begin
          duty[i] <= wv[pwm_width-1:0];
          blink_en[i] <= wv[16];
        end
      presc_cnt <= tick ? '0 : presc_cnt + 1'b1;
      if (tick) pwm_cnt <= pwm_cnt + 1'b1;
      if (period_end) begin
        blink_cnt <= (blink_cnt == blink_half) ? '0 : blink_cnt + 1'b1;
        if (blink_cnt == blink_half) blink_phase <= ~blink_phase;
      end
      for (int i = 0; i < led_count; i++)
        led_state[i] <= enable[i] & (duty[i] > pwm_cnt) & (~blink_en[i] | blink_phase);
    end
  end
endmodule

// File: tb/tb_apb2_led_pwm.sv
// tb_apb2_led_pwm: table-driven APB transactions with a response scoreboard, plus PWM/blink/reset sequences
module tb_apb2_led_pwm;
  logic pclk = 1'b0, preset_n = 1'b0, psel = 1'b0, penable = 1'b0, pwrite = 1'b0;
  logic [7:0] paddr = '0;
  logic [31:0] pwdata = '0, prdata;
  logic [3:0] pstrb = '0;
  logic [2:0] pprot = '0;
  logic pready, pslverr;
  logic [3:0] led_state;
  int total = 0, bad = 0;
  typedef struct { logic w; logic [7:0] a; logic [31:0] d; logic [3:0] s; logic [31:0] er; logic ee; } vec_t;
  typedef struct { logic [31:0] rdata; logic err; } rsp_t;
  vec_t tbl[$];
  rsp_t sb[$];
  apb2_led_pwm dut (.pclk(pclk), .preset_n(preset_n), .psel(psel), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb), .pprot(pprot), .prdata(prdata), .pready(pready),
    .pslverr(pslverr), .led_state(led_state));
  always #5 pclk = ~pclk;
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    total++;
    if (a !== e) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, a, e);
    end
  endtask
  function automatic vec_t mk(input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                              input logic [31:0] er, input logic ee);
    vec_t v;
    v.w = w; v.a = a; v.d = d; v.s = s; v.er = er; v.ee = ee;
    return v;
  endfunction
  task automatic apb(input string n, input logic w, input logic [7:0] a, input logic [31:0] d, input logic [3:0] s,
                     input logic [31:0] er, input logic ee);
    rsp_t r, x;
    logic got;
    r.rdata = er; r.err = ee;
    sb.push_back(r);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    @(negedge pclk);
    penable = 1'b1;
    got = 1'b0;
    for (int k = 0; k < 8 && !got; k++) begin
      @(posedge pclk);
      #1;
      got = pready;
    end
    x = sb.pop_front();
    if (!got) chk({n, "_timeout"}, 32'(got), 32'd1);
    else begin
      chk({n, "_prdata"}, prdata, x.rdata);
      chk({n, "_pslverr"}, 32'(pslverr), 32'(x.err));
    end
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk);
    #1;
    chk({n, "_pready_drop"}, 32'(pready), 32'd0);
  endtask
  initial begin
    int hi, other, run, maxrun, hrun, maxhrun;
    tbl.push_back(mk(0, 8'h0C, 0, 0, 32'h0001_0000, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h04, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h08, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h10, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h1C, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h04, 32'h0000_1234, 4'hF, 0, 0));
    tbl.push_back(mk(1, 8'h04, 32'hAABB_CCDD, 4'h1, 0, 0));
    tbl.push_back(mk(0, 8'h04, 0, 0, 32'h0000_12DD, 0));
    tbl.push_back(mk(1, 8'h0C, 32'hFF, 4'hF, 0, 1));
    tbl.push_back(mk(0, 8'h06, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'h20, 0, 0, 0, 1));
    tbl.push_back(mk(0, 8'h0C, 0, 0, 32'h0001_0000, 0));
    tbl.push_back(mk(1, 8'h00, 32'hF, 4'h0, 0, 0));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h02, 32'hF, 4'hF, 0, 1));
    tbl.push_back(mk(1, 8'h40, 32'hF, 4'hF, 0, 1));
    tbl.push_back(mk(0, 8'h00, 0, 0, 0, 0));
    tbl.push_back(mk(1, 8'h10, 32'h0001_00FF, 4'h4, 0, 0));
    tbl.push_back(mk(0, 8'h10, 0, 0, 32'h0001_0000, 0));
    tbl.push_back(mk(1, 8'h10, 32'h0, 4'hF, 0, 0));
    tbl.push_back(mk(0, 8'h10, 0, 0, 0, 0));
    tbl.push_back(mk(0, 8'h04, 0, 0, 32'h0000_12DD, 0));
    repeat (3) @(posedge pclk);
    #1;
    chk("rst_led", 32'(led_state), 0);
    chk("rst_pready", 32'(pready), 0);
    chk("rst_prdata", prdata, 0);
    chk("rst_pslverr", 32'(pslverr), 0);
    @(negedge pclk);
    preset_n = 1'b1;
    foreach (tbl[i]) apb($sformatf("vec%0d", i), tbl[i].w, tbl[i].a, tbl[i].d, tbl[i].s, tbl[i].er, tbl[i].ee);
    apb("pwm_presc", 1, 8'h04, 0, 4'hF, 0, 0);
    apb("pwm_chan0", 1, 8'h10, 32'h40, 4'hF, 0, 0);
    apb("pwm_en", 1, 8'h00, 32'h1, 4'hF, 0, 0);
    repeat (10) @(negedge pclk);
    hi = 0; other = 0;
    repeat (512) begin
      @(negedge pclk);
      hi += int'(led_state[0]);
      if (led_state[3:1] != 0) other++;
    end
    chk("pwm_high_cycles", hi, 128);
    chk("pwm_other_lit", other, 0);
    apb("blink_chan1", 1, 8'h14, 32'h0001_0080, 4'hF, 0, 0);
    apb("blink_half", 1, 8'h08, 32'h1, 4'hF, 0, 0);
    apb("blink_en", 1, 8'h00, 32'h2, 4'hF, 0, 0);
    repeat (20) @(negedge pclk);
    hi = 0; other = 0; run = 0; maxrun = 0; hrun = 0; maxhrun = 0;
    repeat (2048) begin
      @(negedge pclk);
      if (led_state[1]) begin
        hi++; run = 0; hrun++;
        if (hrun > maxhrun) maxhrun = hrun;
      end else begin
        run++; hrun = 0;
        if (run > maxrun) maxrun = run;
      end
      if (led_state[0] | led_state[2] | led_state[3]) other++;
    end
    chk("blink_high_cycles", hi, 512);
    chk("blink_low_run", maxrun, 640);
    chk("blink_high_run", maxhrun, 128);
    chk("blink_other_lit", other, 0);
    @(negedge pclk);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h00; pwdata = 32'hF; pstrb = 4'hF;
    @(negedge pclk);
    penable = 1'b1; preset_n = 1'b0;
    @(posedge pclk);
    #1;
    chk("rstdrop_pready", 32'(pready), 0);
    chk("rstdrop_led", 32'(led_state), 0);
    @(negedge pclk);
    psel = 1'b0; penable = 1'b0; preset_n = 1'b1;
    apb("rstdrop_enable", 0, 8'h00, 0, 0, 0, 0);
    apb("rstdrop_presc", 0, 8'h04, 0, 0, 0, 0);
    apb("rstdrop_chan1", 0, 8'h14, 0, 0, 0, 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule

// File: doc/apb2_led_pwm.md
Name: apb2_led_pwm

Overview:
- APB2 slave driving `led_count` LED outputs, each with independent 8-bit PWM brightness and optional blink.
- Successor to the single-register LED slave. Adds byte strobes, a multi-register map, a prescaled PWM timebase, a blink generator and error responses.
- Sits on the peripheral APB2 bus next to the other simple MMIO slaves; `led_state` goes straight to the board pins.

Parameters:
- data_width, 32, APB data width; only 32 is supported.
- addr_width, 8, APB address width.
- led_count, 4, number of LED channels, 1..8.
- pwm_width, 8, duty and PWM counter width, 1..16.

Ports:
- pclk  in  1  bus clock; the only clock.
- preset_n  in  1  reset, synchronous, active-low.
- psel  in  1  slave select.
- penable  in  1  APB access phase.
- pwrite  in  1  1 = write, 0 = read.
- paddr  in  addr_width  byte address.
- pwdata  in  data_width  write data.
- pstrb  in  data_width/8  write byte strobes.
- pprot  in  3  ignored.
- prdata  out  data_width  read data.
- pready  out  1  transfer complete.
- pslverr  out  1  error response.
- led_state  out  led_count  LED drive, 1 = lit.

Behaviour:
- Reset: one clock; reset is synchronous and active-low. Ports are named pclk and preset_n.
  - While preset_n=0 at a pclk edge, all registers, counters and outputs clear to 0, except blink_phase which resets to 1.
  - A transfer in flight is dropped; pready stays 0 and the master must retry.
- Register map (word aligned):
  - 0x00 ENABLE, RW, [led_count-1:0] channel enable mask.
  - 0x04 PRESCALE, RW, [15:0].
  - 0x08 BLINK_HALF, RW, [15:0], blink half-period in PWM periods.
  - 0x0C STATUS, RO, [led_count-1:0] = led_state, [16] = blink_phase.
  - 0x10+4*i CHAN_i, RW, for i < led_count: [pwm_width-1:0] duty, [16] blink_en.
  - Unimplemented bits read 0.
- APB handshake, one wait state:
  - Access cycle: psel=1, penable=1, pready=0. At that edge the slave sets pready=1, performs the write or loads prdata, and sets pslverr.
  - pready is held high for exactly one cycle, then returns to 0.
  - Outside that cycle, prdata=0 and pslverr=0. A setup phase alone (penable=0) has no effect.
- Writes honour pstrb per byte; lanes with pstrb=0 are unchanged. pstrb=0 is a legal no-op with an OKAY response.
- pslverr=1 (with pready=1) when any of these holds; no register changes:
  - paddr[1:0] != 0;
  - address unmapped, including CHAN_i with i >= led_count;
  - write to STATUS.
  - Erroring reads return prdata=0.
- Prescaler: presc_cnt increments every pclk. When presc_cnt >= PRESCALE, emit a one-cycle tick and set presc_cnt to 0. PRESCALE=0 gives a tick every cycle. Because the compare is >=, a new smaller PRESCALE never causes a long overrun.
- PWM: pwm_cnt advances on each tick and wraps from 2^pwm_width-1 to 0. That wrap is the period_end strobe.
- Blink:
  - blink_cnt increments on period_end.
  - When blink_cnt == BLINK_HALF and period_end occurs, blink_cnt goes to 0 and blink_phase toggles.
  - BLINK_HALF=0 toggles on every period_end.
- Output, registered (one pclk latency from counter and register state):
  - led_state[i] = ENABLE[i] & (duty_i > pwm_cnt) & (~blink_en_i | blink_phase).
  - duty 0 is always off; the maximum duty is on for (2^pwm_width-1)/2^pwm_width of each period.
- Simultaneous events: a register write and the counter updates occur at the same edge. The new value affects led_state from the next computation, i.e. visible 2 cycles after the write's completing edge.

Test Plan:
- Reset, then read each register -> prdata=0 for all (STATUS=0x00010000); pready high exactly one cycle per read; pslverr=0.
- Write ENABLE=0x1, CHAN_0=0x40, PRESCALE=0 -> led_state[0] high for exactly 64 of every 256 pclk; other channels stay 0.
- CHAN_1=0x1_0080 (blink), ENABLE=0x2, BLINK_HALF=1, PRESCALE=0 -> blink_phase toggles every 512 cycles; led_state[1] is 50 % PWM during phase 1 and constant 0 during phase 0.
- Write 0xAABBCCDD to PRESCALE with pstrb=0b0001 after a prior 0x1234 -> reads back 0x000012DD.
- Errors -> each gives pready=1, pslverr=1, no register changes:
  - write STATUS;
  - read 0x06;
  - read 0x10+4*led_count.
- Assert preset_n=0 in the access cycle of a write to ENABLE -> no pready pulse; ENABLE stays 0; led_state=0 on the next edge.
